dii_packet_arbiter: RTL
=======================

Name: dii_packet_arbiter

Overview:
- Merges PORTS upstream DII channels onto one downstream DII channel. Each DII channel carries 16-bit data with first/last/valid/ready.
- Arbitration is packet-granular round-robin. A grant is held from the first beat to the last beat, so packets never interleave.
- Sits between several debug modules and a single debug_ring port, or in front of the host interface module's dii_in. This lets modules share one ring attachment.

Parameters:
- PORTS, 2, number of upstream DII channels (2..8).
- WIDTH, 16, DII data width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_flat_data  input  PORTS*WIDTH  upstream data; port i occupies bits [i*WIDTH +: WIDTH].
- in_flat_first  input  PORTS  first-beat flag per port.
- in_flat_last  input  PORTS  last-beat flag per port.
- in_flat_valid  input  PORTS  valid per port.
- in_flat_ready  output  PORTS  ready per port.
- out_data  output  WIDTH  downstream data.
- out_first  output  1  downstream first.
- out_last  output  1  downstream last.
- out_valid  output  1  downstream valid.
- out_ready  input  1  downstream ready.
- grant  output  PORTS  one-hot current owner; 0 when idle.
- err_protocol  output  1  sticky; set on orphan or misplaced-first beat; cleared only by rst.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst); all state updates on posedge clk.
- Transfer on a channel = valid & ready in the same cycle.
- Reset values: grant=0, state=IDLE, rr_ptr=0, beat_seen=0, err_protocol=0. Consequently out_valid=0 and in_flat_ready=0 while rst is high.
- States: IDLE, BUSY.
- IDLE:
  - req[i] = valid[i] & first[i].
  - Winner = first index with req set, scanning rr_ptr, rr_ptr+1, ... mod PORTS.
  - If any req: next cycle grant=onehot(winner), state=BUSY, beat_seen=0.
  - out_valid=0 in IDLE. This gives a 1-cycle arbitration bubble, i.e. 1 cycle from first-beat valid to out_valid.
  - Orphan beat (valid[i] & ~first[i]): in_flat_ready[i]=1, beat is dropped, err_protocol set.
  - Ports with req are held (ready=0).
- BUSY, with g = granted index:
  - out_data/first/last/valid = in[g] combinationally.
  - in_flat_ready[g] = out_ready; all other ready=0.
  - On a transfer: beat_seen=1.
  - If first=1 on a transfer while beat_seen=1: set err_protocol and still forward the beat.
  - On a transfer with last=1: next cycle state=IDLE, grant=0, rr_ptr=(g+1) mod PORTS.
  - Single-beat packet (first=last=1) completes in one BUSY cycle.
- No drop of a granted beat; out_valid never deasserts without a transfer unless upstream deasserts valid. The arbiter does not buffer.
- Back-to-back packets: minimum 1 idle cycle between packets at the output. Throughput = 1 beat/cycle inside a packet.
- Simultaneous requests: resolved strictly by rr_ptr. After a packet from port k completes, port k has the lowest priority.
- Reset mid-packet: immediate return to IDLE, grant=0, rr_ptr=0. The partial packet is abandoned; its remaining beats arrive as orphans and are dropped with err_protocol set.
- rr_ptr wraps from PORTS-1 to 0.
- Width rule: rr_ptr and the grant index are $clog2(PORTS) bits wide; the mod-PORTS wrap is explicit for non-power-of-two PORTS.

Test Plan:
- Reset, then one 3-beat packet on port 1 (data 0x0011/0x0022/0x0033, out_ready=1) -> grant=2'b10 one cycle after the first valid; out shows the 3 beats on consecutive cycles with first on 0x0011 and last on 0x0033; grant=0 the cycle after last; rr_ptr=0.
- Ports 0 and 1 both hold 2-beat packets from the same cycle, PORTS=2 -> port 0 served first, then after 1 idle cycle port 1. Then re-present both -> port 0 wins again, since rr_ptr returned to 0 after port 1.
- out_ready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; in_flat_ready[g] mirrors out_ready; non-granted port ready stays 0 throughout.
- Orphan beat on port 1 (valid=1, first=0, data 0xDEAD) while IDLE -> in_flat_ready[1]=1 for one cycle, out_valid stays 0, err_protocol=1 and remains set.
- rst asserted on beat 2 of a 4-beat packet -> next cycle grant=0 and out_valid=0. Beats 3–4 are dropped as orphans and err_protocol=1. A new packet afterwards is granted normally.
- PORTS=3, single-beat packets on all ports continuously -> grant sequence 0,1,2,0,1,2, one packet every 2 cycles.

Source files
------------

// File: rtl/dii_packet_arbiter.sv
// dii_packet_arbiter
//
// Merges PORTS upstream DII channels onto a single downstream DII channel.
// Arbitration is packet-granular round-robin: once a port wins, it owns the
// output from its first beat through its last beat, so packets never
// interleave. The arbiter adds no buffering. Downstream signals are a
// combinational pass-through of the granted port.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   in_flat_data   upstream data, port i at [i*WIDTH +: WIDTH]
//   in_flat_first  per-port first-beat flag
//   in_flat_last   per-port last-beat flag
//   in_flat_valid  per-port valid
//   in_flat_ready  per-port ready
//   out_data       downstream data
//   out_first      downstream first-beat flag
//   out_last       downstream last-beat flag
//   out_valid      downstream valid
//   out_ready      downstream ready
//   grant          one-hot current owner, zero while idle
//   err_protocol   sticky protocol error (orphan beat, or a first flag
//                  arriving after a packet's first beat); cleared by rst only

module dii_packet_arbiter #(
    parameter int PORTS = 2,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS*WIDTH-1:0]   in_flat_data,
    input  logic [PORTS-1:0]         in_flat_first,
    input  logic [PORTS-1:0]         in_flat_last,
    input  logic [PORTS-1:0]         in_flat_valid,
    output logic [PORTS-1:0]         in_flat_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PORTS-1:0]         grant,
    output logic                     err_protocol
);

    localparam int          IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned NP = PORTS;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic             beat_seen_q, beat_seen_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] in_data [PORTS];
    logic [PORTS-1:0] req;
    logic [PORTS-1:0] orphan;
    logic [IW-1:0]    winner;
    logic             win_found;
    int unsigned      scan_idx;
    logic             xfer;

    // Unpack the flat data bus so the granted port can be selected by index.
    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            in_data[i] = in_flat_data[i*WIDTH +: WIDTH];
        end
    end

    assign req    = in_flat_valid & in_flat_first;
    assign orphan = in_flat_valid & ~in_flat_first;

    // Round-robin scan starting at rr_ptr. The wrap is done by subtraction
    // so non-power-of-two PORTS never index past the last port.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NP; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NP) begin
                scan_idx = scan_idx - NP;
            end
            if (!win_found && req[scan_idx[IW-1:0]]) begin
                win_found = 1'b1;
                winner    = scan_idx[IW-1:0];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        gidx_d        = gidx_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        beat_seen_d   = beat_seen_q;
        err_d         = err_q;
        in_flat_ready = '0;
        out_valid     = 1'b0;
        out_data      = in_data[gidx_q];
        out_first     = in_flat_first[gidx_q];
        out_last      = in_flat_last[gidx_q];
        xfer          = 1'b0;

        case (state_q)
            IDLE: begin
                // Orphans are accepted and dropped; requesters are held
                // until they are granted.
                in_flat_ready = orphan;
                if (|orphan) begin
                    err_d = 1'b1;
                end
                if (win_found) begin
                    state_d     = BUSY;
                    gidx_d      = winner;
                    grant_d     = PORTS'(1) << winner;
                    beat_seen_d = 1'b0;
                end
            end

            BUSY: begin
                out_valid             = in_flat_valid[gidx_q];
                in_flat_ready[gidx_q] = out_ready;
                xfer                  = in_flat_valid[gidx_q] & out_ready;
                if (xfer) begin
                    beat_seen_d = 1'b1;
                    // A second first flag is flagged but still forwarded.
                    if (in_flat_first[gidx_q] && beat_seen_q) begin
                        err_d = 1'b1;
                    end
                    if (in_flat_last[gidx_q]) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (gidx_q == IW'(PORTS - 1)) ? '0 : gidx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Nothing handshakes while reset is held, even mid-packet.
        if (rst) begin
            in_flat_ready = '0;
            out_valid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gidx_q      <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_seen_q <= beat_seen_d;
            err_q       <= err_d;
        end
    end

    assign grant        = grant_q;
    assign err_protocol = err_q;

endmodule
